pulse_bit_deframer: RTL and testbench
=====================================

PULSE_BIT_DEFRAMER -- requirements
Module: pulse_bit_deframer

Interface
REQ-001 The block SHALL have parameter SFD, default 8'hD5, start-of-frame delimiter searched MSB-first.
REQ-002 The block SHALL have parameter MAX_LEN, default 64, largest legal payload length in bytes (1..255).
REQ-003 The block SHALL have port clk_fast  input  1  single clock; all logic on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port enable  input  1  block enable; low forces IDLE.
REQ-006 The block SHALL have port sync_locked  input  1  phase-search lock indication from upstream.
REQ-007 The block SHALL have port sync_clk  input  1  selected gate window from upstream, one high run per bit.
REQ-008 The block SHALL have port adc_pulse  input  1  raw pulse detector output.
REQ-009 The block SHALL have port byte_data  output  8  received byte (length or payload).
REQ-010 The block SHALL have port byte_valid  output  1  one-cycle strobe qualifying payload byte_data.
REQ-011 The block SHALL have port frame_len  output  8  length byte of current frame, held until next length byte.
REQ-012 The block SHALL have port frame_active  output  1  high in LEN, DATA (and CRC) states.
REQ-013 The block SHALL have port frame_done  output  1  one-cycle strobe on good frame end.
REQ-014 The block SHALL have port frame_err  output  1  one-cycle strobe on aborted or bad frame.
REQ-015 The block SHALL have port crc_ok  output  1  CRC result, valid with frame_done/frame_err.

Function
REQ-016 The block SHALL latch a pulse flag when adc_pulse=1 while sync_clk=1, and clear it after each bit decision.
REQ-017 The block SHALL make a bit decision in the cycle sync_clk is 0 and was 1 the previous cycle; bit = pulse flag (pulse in same cycle as falling gate excluded).
REQ-018 Bit decisions SHALL be ignored unless enable=1 and sync_locked=1.
REQ-019 Bits SHALL shift MSB-first into an 8-bit register: sh <= {sh[6:0], bit}.
REQ-020 States SHALL be IDLE, HUNT, LEN, DATA, CRC; IDLE -> HUNT when enable & sync_locked.
REQ-021 HUNT SHALL compare sh after every bit; match with SFD -> LEN, bit counter cleared.
REQ-022 LEN SHALL collect 8 bits into frame_len; 1..MAX_LEN -> DATA; 0 or >MAX_LEN -> frame_err, HUNT.
REQ-023 DATA SHALL output each completed byte on byte_data with byte_valid for one cycle, the cycle after its 8th bit decision.
REQ-024 After frame_len payload bytes, the block SHALL go to CRC (macro defined) or pulse frame_done and go to HUNT.
REQ-025 sync_locked or enable falling in LEN/DATA/CRC SHALL abort: frame_err pulse next cycle, state IDLE, partial byte discarded.
REQ-026 sync_locked or enable falling in HUNT SHALL go to IDLE without frame_err.
REQ-027 byte_valid, frame_done, frame_err SHALL be mutually exclusive and never high two consecutive cycles for the same event.
REQ-028 HUNT SHALL clear sh on entry so an SFD is never matched from pre-frame bits.

Reset
REQ-029 rst_n=0 SHALL asynchronously force state IDLE, sh, counters, pulse flag to 0.
REQ-030 Reset values: byte_data=0, byte_valid=0, frame_len=0, frame_active=0, frame_done=0, frame_err=0, crc_ok=0.
REQ-031 Reset mid-frame SHALL produce no frame_err pulse.

Configuration
REQ-032 With DEFRAME_CRC8_EN defined, the block SHALL compute CRC-8 (poly 0x07, init 0x00, MSB-first) over payload bytes, receive one trailing CRC byte in state CRC, and pulse frame_done with crc_ok=1 on match or frame_err with crc_ok=0 on mismatch.
REQ-033 Without DEFRAME_CRC8_EN, state CRC SHALL be absent, no trailing byte consumed, and crc_ok SHALL be 1 with every frame_done and 0 with frame_err.

Verification
REQ-034 Locked, bits D5,03,11,22,33 -> byte_valid x3 with 11,22,33, frame_len=3, frame_done (macro off).
REQ-035 Macro on, D5,01,AA,CRC=0x5F -> byte AA, frame_done, crc_ok=1; same with CRC 0x00 -> frame_err, crc_ok=0.
REQ-036 Length byte 00 or MAX_LEN+1 after SFD -> frame_err, no byte_valid, return to HUNT.
REQ-037 sync_locked dropped after 4 bits of second payload byte -> one frame_err, IDLE, no byte_valid for partial byte.
REQ-038 adc_pulse only while sync_clk=0 for 16 windows -> all bits 0, no SFD match, frame_active=0.
REQ-039 rst_n asserted during DATA -> all outputs 0 immediately, no frame_err, HUNT after release and relock.

Source files
------------

// File: rtl/pulse_bit_deframer.sv
// pulse_bit_deframer: gated pulse-bit receiver, SFD hunt, length framing.
// Define DEFRAME_CRC8_EN to add a trailing CRC-8 byte check per frame.
module pulse_bit_deframer #(
  parameter logic [7:0] SFD     = 8'hD5,
  parameter int         MAX_LEN = 64
) (
  input  logic       clk_fast,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       sync_locked,
  input  logic       sync_clk,
  input  logic       adc_pulse,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic [7:0] frame_len,
  output logic       frame_active,
  output logic       frame_done,
  output logic       frame_err,
  output logic       crc_ok
);

  localparam logic [7:0] MAXL = 8'(MAX_LEN);

`ifdef DEFRAME_CRC8_EN
  typedef enum logic [2:0] {
    S_IDLE, S_HUNT, S_LEN, S_DATA, S_CRC
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_HUNT, S_LEN, S_DATA
  } state_e;
`endif

  state_e     state_q, state_d;
  logic       sync_q;
  logic       pulse_q, pulse_d;
  logic [7:0] sh_q, sh_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic [7:0] ycnt_q, ycnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic [7:0] len_q, len_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       crcok_q, crcok_d;
`ifdef DEFRAME_CRC8_EN
  logic [7:0] crc_q, crc_d;
`else
  logic       pend_q, pend_d;
`endif

  logic       run;
  logic       fall;
  logic       bit_ev;
  logic       act;
  logic       last_bit;
  logic       last_byte;
  logic [7:0] sh_sft;

`ifdef DEFRAME_CRC8_EN
  function automatic logic [7:0] crc8_upd(
    input logic [7:0] c,
    input logic [7:0] d
  );
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07)
               : {r[6:0], 1'b0};
    end
    return r;
  endfunction
`endif

  assign run       = enable & sync_locked;
  assign fall      = sync_q & ~sync_clk;
  assign bit_ev    = run & fall;
  assign sh_sft    = {sh_q[6:0], pulse_q};
  assign last_bit  = (bcnt_q == 3'd7);
  assign last_byte = (8'(ycnt_q + 8'd1) == len_q);
`ifdef DEFRAME_CRC8_EN
  assign act = (state_q == S_LEN) || (state_q == S_DATA) ||
               (state_q == S_CRC);
`else
  assign act = (state_q == S_LEN) || (state_q == S_DATA);
`endif

  // Next-state, bit shifting and registered strobe generation
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bcnt_d  = bcnt_q;
    ycnt_d  = ycnt_q;
    data_d  = data_q;
    valid_d = 1'b0;
    len_d   = len_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    crcok_d = crcok_q;
`ifdef DEFRAME_CRC8_EN
    crc_d   = crc_q;
`else
    pend_d  = 1'b0;
    if (pend_q) begin
      done_d  = 1'b1;
      crcok_d = 1'b1;
    end
`endif
    pulse_d = pulse_q;
    if (fall) begin
      pulse_d = 1'b0;
    end else if (adc_pulse && sync_clk) begin
      pulse_d = 1'b1;
    end

    if (!run) begin
      state_d = S_IDLE;
      if (act) begin
        err_d   = 1'b1;
        crcok_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_HUNT;
          sh_d    = 8'd0;
        end
        S_HUNT: begin
          if (bit_ev) begin
            sh_d = sh_sft;
            if (sh_sft == SFD) begin
              state_d = S_LEN;
              bcnt_d  = 3'd0;
            end
          end
        end
        S_LEN: begin
          if (bit_ev) begin
            sh_d   = sh_sft;
            bcnt_d = bcnt_q + 3'd1;
            if (last_bit) begin
              len_d = sh_sft;
              if (sh_sft == 8'd0 || sh_sft > MAXL) begin
                err_d   = 1'b1;
                crcok_d = 1'b0;
                state_d = S_HUNT;
                sh_d    = 8'd0;
              end else begin
                state_d = S_DATA;
                ycnt_d  = 8'd0;
`ifdef DEFRAME_CRC8_EN
                crc_d   = 8'd0;
`endif
              end
            end
          end
        end
        S_DATA: begin
          if (bit_ev) begin
            sh_d   = sh_sft;
            bcnt_d = bcnt_q + 3'd1;
            if (last_bit) begin
              data_d  = sh_sft;
              valid_d = 1'b1;
              ycnt_d  = ycnt_q + 8'd1;
`ifdef DEFRAME_CRC8_EN
              crc_d   = crc8_upd(crc_q, sh_sft);
              if (last_byte) begin
                state_d = S_CRC;
              end
`else
              if (last_byte) begin
                pend_d  = 1'b1;
                state_d = S_HUNT;
                sh_d    = 8'd0;
              end
`endif
            end
          end
        end
`ifdef DEFRAME_CRC8_EN
        S_CRC: begin
          if (bit_ev) begin
            sh_d   = sh_sft;
            bcnt_d = bcnt_q + 3'd1;
            if (last_bit) begin
              if (sh_sft == crc_q) begin
                done_d  = 1'b1;
                crcok_d = 1'b1;
              end else begin
                err_d   = 1'b1;
                crcok_d = 1'b0;
              end
              state_d = S_HUNT;
              sh_d    = 8'd0;
            end
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sync_q  <= 1'b0;
      pulse_q <= 1'b0;
      sh_q    <= 8'd0;
      bcnt_q  <= 3'd0;
      ycnt_q  <= 8'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      len_q   <= 8'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      crcok_q <= 1'b0;
`ifdef DEFRAME_CRC8_EN
      crc_q   <= 8'd0;
`else
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync_q  <= sync_clk;
      pulse_q <= pulse_d;
      sh_q    <= sh_d;
      bcnt_q  <= bcnt_d;
      ycnt_q  <= ycnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      len_q   <= len_d;
      done_q  <= done_d;
      err_q   <= err_d;
      crcok_q <= crcok_d;
`ifdef DEFRAME_CRC8_EN
      crc_q   <= crc_d;
`else
      pend_q  <= pend_d;
`endif
    end
  end

  assign byte_data    = data_q;
  assign byte_valid   = valid_q;
  assign frame_len    = len_q;
  assign frame_active = act;
  assign frame_done   = done_q;
  assign frame_err    = err_q;
  assign crc_ok       = crcok_q;

endmodule

// File: tb/tb_pulse_bit_deframer.sv
// tb_pulse_bit_deframer: random gated bit stream vs frame-level model.
// Directed frames pin the model; DEFRAME_CRC8_EN selects CRC variant.
`timescale 1ns/1ps
module tb_pulse_bit_deframer;

  localparam logic [7:0] SFD_T  = 8'hD5;
  localparam int         MAXL_T = 64;

  logic       clk_fast = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       sync_locked;
  logic       sync_clk;
  logic       adc_pulse;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic [7:0] frame_len;
  logic       frame_active;
  logic       frame_done;
  logic       frame_err;
  logic       crc_ok;

  pulse_bit_deframer #(
    .SFD     (SFD_T),
    .MAX_LEN (MAXL_T)
  ) dut (
    .clk_fast     (clk_fast),
    .rst_n        (rst_n),
    .enable       (enable),
    .sync_locked  (sync_locked),
    .sync_clk     (sync_clk),
    .adc_pulse    (adc_pulse),
    .byte_data    (byte_data),
    .byte_valid   (byte_valid),
    .frame_len    (frame_len),
    .frame_active (frame_active),
    .frame_done   (frame_done),
    .frame_err    (frame_err),
    .crc_ok       (crc_ok)
  );

  always #5 clk_fast = ~clk_fast;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_v   = 0;
  int n_d   = 0;
  int n_e   = 0;
  bit chk_on = 0;

  always @(posedge clk_fast) cyc++;

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // ---------------- frame-level model ----------------
  localparam int K_BYTE = 0, K_DONE = 1, K_ERR = 2;
  localparam int K_LEN = 3, K_ON = 4, K_OFF = 5;
  typedef struct { int cyc; int kind; int val; } ev_t;
  ev_t q[$];

  int         mode;   // 0 idle, 1 hunt, 2 len, 3 data, 4 crc
  bit         bq[$];
  int         remaining;
  logic [7:0] mcrc;

  function automatic logic [7:0] crc8(input logic [7:0] c,
                                      input logic [7:0] d);
    logic [15:0] r;
    r = {c ^ d, 8'h00};
    for (int i = 15; i >= 8; i--)
      if (r[i]) r = r ^ (16'h0107 << (i - 8));
    return r[7:0];
  endfunction

  function automatic logic [7:0] last8();
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v = {v[6:0], bq[bq.size() - 8 + i]};
    return v;
  endfunction

  task automatic push(input int c, input int k, input int v);
    ev_t e;
    e.cyc = c; e.kind = k; e.val = v;
    q.push_back(e);
  endtask

  task automatic model_reset();
    q.delete(); bq.delete(); mode = 0;
  endtask

  task automatic model_abort(input int d);
    if (mode >= 2) begin
      push(d, K_ERR, 0);
      push(d, K_OFF, 0);
    end
    mode = 0;
    bq.delete();
  endtask

  task automatic model_bit(input bit b, input int d);
    logic [7:0] v;
    bq.push_back(b);
    case (mode)
      1: begin
        if (bq.size() > 8) void'(bq.pop_front());
        if (bq.size() == 8 && last8() == SFD_T) begin
          mode = 2; bq.delete(); push(d, K_ON, 0);
        end
      end
      2: if (bq.size() == 8) begin
        v = last8(); bq.delete();
        push(d, K_LEN, v);
        if (v == 0 || v > MAXL_T) begin
          push(d, K_ERR, 0); push(d, K_OFF, 0); mode = 1;
        end else begin
          mode = 3; remaining = v; mcrc = 8'h00;
        end
      end
      3: if (bq.size() == 8) begin
        v = last8(); bq.delete();
        push(d, K_BYTE, v);
        mcrc = crc8(mcrc, v);
        remaining--;
        if (remaining == 0) begin
`ifdef DEFRAME_CRC8_EN
          mode = 4;
`else
          push(d, K_OFF, 0); push(d + 1, K_DONE, 1); mode = 1;
`endif
        end
      end
      4: if (bq.size() == 8) begin
        v = last8(); bq.delete();
        if (v == mcrc) push(d, K_DONE, 1);
        else push(d, K_ERR, 0);
        push(d, K_OFF, 0); mode = 1;
      end
      default: bq.delete();
    endcase
  endtask

  // ---------------- per-cycle compare ----------------
  logic       e_v, e_d, e_e, exp_act, exp_crc;
  logic [7:0] exp_len, exp_data;
  ev_t        ev;

  always @(negedge clk_fast) begin
    if (rst_n && chk_on) begin
      e_v = 0; e_d = 0; e_e = 0;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        ev = q.pop_front();
        case (ev.kind)
          K_BYTE: begin e_v = 1; exp_data = 8'(ev.val); end
          K_DONE: begin e_d = 1; exp_crc = ev.val[0]; end
          K_ERR:  begin e_e = 1; exp_crc = 1'b0; end
          K_LEN:  exp_len = 8'(ev.val);
          K_ON:   exp_act = 1'b1;
          default: exp_act = 1'b0;
        endcase
      end
      check("byte_valid", byte_valid, e_v);
      check("frame_done", frame_done, e_d);
      check("frame_err", frame_err, e_e);
      check("frame_active", frame_active, exp_act);
      check("frame_len", frame_len, exp_len);
      if (e_v) check("byte_data", byte_data, exp_data);
      if (e_d || e_e) check("crc_ok", crc_ok, exp_crc);
      if (byte_valid) n_v++;
      if (frame_done) n_d++;
      if (frame_err) n_e++;
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk_fast); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_bit(input bit b);
    int h, l, pc;
    h  = $urandom_range(2, 4);
    l  = $urandom_range(2, 4);
    pc = $urandom_range(0, h - 1);
    for (int i = 0; i < h; i++) begin
      sync_clk  = 1'b1;
      adc_pulse = b && (i == pc || $urandom_range(0, 3) == 0);
      tick();
    end
    sync_clk  = 1'b0;
    adc_pulse = ($urandom_range(0, 2) == 0);
    if (enable && sync_locked) model_bit(b, cyc + 1);
    for (int i = 0; i < l; i++) begin
      tick();
      adc_pulse = ($urandom_range(0, 2) == 0);
    end
    adc_pulse = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic set_run(input logic lk, input logic en);
    logic was, now;
    was = sync_locked & enable;
    now = lk & en;
    sync_locked = lk;
    enable      = en;
    if (was && !now) model_abort(cyc + 1);
    if (!was && now) begin mode = 1; bq.delete(); end
    idle(3);
  endtask

  task automatic hard_reset_checks(input string tag);
    check({tag, "_byte_data"}, byte_data, 8'h00);
    check({tag, "_byte_valid"}, byte_valid, 1'b0);
    check({tag, "_frame_len"}, frame_len, 8'h00);
    check({tag, "_frame_active"}, frame_active, 1'b0);
    check({tag, "_frame_done"}, frame_done, 1'b0);
    check({tag, "_frame_err"}, frame_err, 1'b0);
    check({tag, "_crc_ok"}, crc_ok, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int         v0, d0, e0, len, ab_at, nb;
  logic [7:0] tcrc, pb;

  initial begin
    rst_n = 0; enable = 0; sync_locked = 0;
    sync_clk = 0; adc_pulse = 0;
    model_reset();
    exp_act = 0; exp_len = 0; exp_data = 0; exp_crc = 0;
    idle(3);
    hard_reset_checks("reset");
    rst_n = 1; chk_on = 1;
    idle(2);
    set_run(1, 1);

    // pulses only outside the gate: all bits zero
    v0 = n_v + n_d + n_e;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 3; j++) begin
        sync_clk = 1'b1; adc_pulse = 1'b0; tick();
      end
      sync_clk = 1'b0;
      model_bit(1'b0, cyc + 1);
      for (int j = 0; j < 3; j++) begin adc_pulse = 1'b1; tick(); end
      adc_pulse = 1'b0;
    end
    idle(4);
    check("noise_strobes", n_v + n_d + n_e - v0, 0);
    check("noise_active", frame_active, 1'b0);

    // D5 03 11 22 33
    v0 = n_v; d0 = n_d; e0 = n_e;
    send_byte(8'hD5); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
`ifdef DEFRAME_CRC8_EN
    tcrc = crc8(crc8(crc8(8'h00, 8'h11), 8'h22), 8'h33);
    send_byte(tcrc);
`endif
    idle(4);
    check("f1_valid_cnt", n_v - v0, 3);
    check("f1_done_cnt", n_d - d0, 1);
    check("f1_err_cnt", n_e - e0, 0);
    check("f1_len", frame_len, 8'h03);
    check("f1_last_byte", byte_data, 8'h33);
    check("f1_crc_ok", crc_ok, 1'b1);

    // single byte AA
    d0 = n_d; e0 = n_e;
    send_byte(8'hD5); send_byte(8'h01); send_byte(8'hAA);
`ifdef DEFRAME_CRC8_EN
    send_byte(8'h5F);
`endif
    idle(4);
    check("aa_done_cnt", n_d - d0, 1);
    check("aa_crc_ok", crc_ok, 1'b1);
`ifdef DEFRAME_CRC8_EN
    e0 = n_e;
    send_byte(8'hD5); send_byte(8'h01); send_byte(8'hAA);
    send_byte(8'h00);
    idle(4);
    check("badcrc_err_cnt", n_e - e0, 1);
    check("badcrc_crc_ok", crc_ok, 1'b0);
`endif

    // illegal lengths 0 and MAX_LEN+1
    v0 = n_v; e0 = n_e;
    send_byte(8'hD5); send_byte(8'h00);
    idle(4);
    check("len0_err_cnt", n_e - e0, 1);
    check("len0_active", frame_active, 1'b0);
    send_byte(8'hD5); send_byte(8'(MAXL_T + 1));
    idle(4);
    check("lenmax_err_cnt", n_e - e0, 2);
    check("lenmax_len", frame_len, 8'h41);
    check("badlen_valid_cnt", n_v - v0, 0);

    // lock lost 4 bits into second payload byte
    v0 = n_v; e0 = n_e;
    send_byte(8'hD5); send_byte(8'h05); send_byte(8'hAA);
    send_bit(1); send_bit(0); send_bit(1); send_bit(0);
    set_run(0, 1);
    idle(2);
    check("abort_err_cnt", n_e - e0, 1);
    check("abort_valid_cnt", n_v - v0, 1);
    check("abort_active", frame_active, 1'b0);
    set_run(1, 1);

    // reset in the middle of payload
    e0 = n_e;
    send_byte(8'hD5); send_byte(8'h04); send_byte(8'h11);
    send_bit(1); send_bit(1); send_bit(0);
    rst_n = 0;
    #1;
    hard_reset_checks("midrst");
    model_reset();
    exp_act = 0; exp_len = 0; exp_data = 0; exp_crc = 0;
    sync_locked = 0;
    idle(3);
    rst_n = 1;
    idle(3);
    check("midrst_no_err", n_e - e0, 0);
    set_run(1, 1);
    d0 = n_d;
    send_byte(8'hD5); send_byte(8'h01); send_byte(8'h5A);
`ifdef DEFRAME_CRC8_EN
    send_byte(crc8(8'h00, 8'h5A));
`endif
    idle(4);
    check("relock_done_cnt", n_d - d0, 1);
    check("relock_len", frame_len, 8'h01);

    // randomized frames with garbage, bad lengths and aborts
    for (int f = 0; f < 25; f++) begin
      nb = $urandom_range(0, 10);
      for (int i = 0; i < nb; i++) send_bit(1'($urandom_range(0, 1)));
      case ($urandom_range(0, 15))
        0: len = MAXL_T;
        1: len = 0;
        2: len = MAXL_T + 1;
        default: len = $urandom_range(1, 5);
      endcase
      send_byte(SFD_T);
      send_byte(8'(len));
      if (len >= 1 && len <= MAXL_T) begin
        ab_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len - 1) : -1;
        tcrc = 8'h00;
        for (int i = 0; i < len; i++) begin
          pb = 8'($urandom_range(0, 255));
          if (i == ab_at) begin
            nb = $urandom_range(1, 7);
            for (int j = 0; j < nb; j++) send_bit(pb[7 - j]);
            if ($urandom_range(0, 1) == 1) set_run(0, 1);
            else set_run(1, 0);
            set_run(1, 1);
            break;
          end
          send_byte(pb);
          tcrc = crc8(tcrc, pb);
        end
`ifdef DEFRAME_CRC8_EN
        if (ab_at < 0) begin
          if ($urandom_range(0, 3) == 0)
            tcrc = tcrc ^ (8'h01 << $urandom_range(0, 7));
          send_byte(tcrc);
        end
`endif
      end
    end

    idle(10);
    check("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
